avr_cpu_regfile: RTL and testbench
==================================

Name: avr_cpu_regfile

Overview:
- Architectural register file for the AVR core: 32 x 8-bit general registers (r0..r31) plus the status register SREG.
- Sits directly upstream and downstream of avr_cpu_alu:
  - supplies r_in, d_in and status_in;
  - captures the ALU result and status_out at writeback.
- Also exports the X/Y/Z pointer pairs for the load/store unit and a 16-bit pair read for word instructions (ADIW/SBIW/MOVW).

Parameters:
- REG_RESET, 8'h00, value loaded into every general register on reset.
- SREG_RESET, 8'h00, value loaded into SREG on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- r_addr  in  5  source register select; drives r_out (to ALU r_in).
- d_addr  in  5  destination/second-operand select; drives d_out (to ALU d_in).
- r_out  out  8  contents of r[r_addr].
- d_out  out  8  contents of r[d_addr].
- d_word_out  out  16  {r[d_addr|1], r[d_addr&~1]}, register pair containing d_addr.
- wr_en  in  1  register write strobe.
- wr_word  in  1  1 = 16-bit pair write, 0 = byte write.
- wr_addr  in  5  write target register (pair base when wr_word=1).
- wr_data  in  8  byte data / low byte of pair (from ALU out).
- wr_data_hi  in  8  high byte of pair write.
- status_out  out  8  current SREG (to ALU status_in).
- sreg_wr_mask  in  8  per-bit SREG write enable.
- sreg_wr_data  in  8  new SREG bits (from ALU status_out).
- x_ptr, y_ptr, z_ptr  out  16 each  {r27,r26}, {r29,r28}, {r31,r30}.

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-write): all r0..r31 <= REG_RESET; SREG <= SREG_RESET. All outputs reflect these values combinationally while rst is held. Writes presented during reset are discarded.
- Reads are combinational from the storage array. There is no write-to-read bypass: a read of a register being written in the same cycle returns the old value; the new value is visible the cycle after the edge.
- Byte write (wr_en=1, wr_word=0): r[wr_addr] <= wr_data at posedge clk.
- Word write (wr_en=1, wr_word=1):
  - wr_addr[0]=0: r[wr_addr] <= wr_data and r[wr_addr+1] <= wr_data_hi, in the same edge.
  - wr_addr[0]=1: illegal; no register is modified (checked by an assertion in simulation).
- wr_en=0: no general register changes, regardless of wr_word/wr_addr.
- SREG update every posedge: SREG <= (SREG & ~sreg_wr_mask) | (sreg_wr_data & sreg_wr_mask).
  - mask=8'h00 holds SREG.
  - Single-bit masks implement BSET/BCLR.
  - ALU ops pass the mask of the flags they affect.
- SREG and register writes are independent; both may occur in one cycle with no priority interaction.
- Register addresses wrap naturally at 5 bits; there is no out-of-range case.
- d_word_out ignores d_addr[0], so pair reads are always aligned.
- Latency: write-to-read 1 cycle; read 0 cycles.

Decomposition:
- Shared package avr_cpu_pkg:
  - SREG bit indices C=0, Z=1, N=2, V=3, S=4, H=5, T=6, I=7;
  - pointer base addresses X=26, Y=28, Z=30;
  - REG_COUNT=32.
- One natural sub-module, avr_cpu_sreg: the masked-update 8-bit status register with async reset. The general register array stays inline.

Test Plan:
1. Assert rst mid-cycle after writing r5=8'hAA -> r_out for r_addr=5 reads 8'h00 immediately, without waiting for an edge; status_out=8'h00.
2. Byte write r16=8'd40, then r17=8'd50 -> next cycle r_addr=17, d_addr=16 gives r_out=50, d_out=40. Feed ALU add out=90 back as wr_addr=16 -> r16=90 the following cycle.
3. Same-cycle read/write of r16 (old 8'd40, new 8'd240) -> d_out=40 that cycle, 240 the next.
4. Word write wr_addr=26, wr_data=8'h34, wr_data_hi=8'h12 -> x_ptr=16'h1234; d_addr=27 gives d_word_out=16'h1234. Word write to wr_addr=27 -> no register changes.
5. SREG=8'h00; sreg_wr_mask=8'h3F, sreg_wr_data=8'hC3 -> SREG=8'h03. Then mask=8'h80, data=8'h80 -> SREG=8'h83. Then mask=8'h00 -> SREG stays 8'h83.
6. Simultaneous byte write r0=8'h55 and SREG mask=8'h01/data=8'h01 -> both take effect on the same edge.

Source files
------------

// File: rtl/avr_cpu_pkg.sv
// Shared AVR core constants: SREG flag positions, pointer pair bases, register count.
package avr_cpu_pkg;

  localparam int REG_COUNT = 32;

  localparam int SREG_C = 0;
  localparam int SREG_Z = 1;
  localparam int SREG_N = 2;
  localparam int SREG_V = 3;
  localparam int SREG_S = 4;
  localparam int SREG_H = 5;
  localparam int SREG_T = 6;
  localparam int SREG_I = 7;

  localparam logic [4:0] X_BASE = 5'd26;
  localparam logic [4:0] Y_BASE = 5'd28;
  localparam logic [4:0] Z_BASE = 5'd30;

  // Bits selected by mask take the new value, all others keep the current one.
  function automatic logic [7:0] sreg_merge(input logic [7:0] cur,
                                            input logic [7:0] mask,
                                            input logic [7:0] data);
    return (cur & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/avr_cpu_sreg.sv
// AVR status register with per-bit write mask; a zero mask holds the current value.
module avr_cpu_sreg
  import avr_cpu_pkg::*;
#(
  parameter logic [7:0] SREG_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_mask,
  input  logic [7:0] wr_data,
  output logic [7:0] sreg
);

  logic [7:0] sreg_reg;
  logic [7:0] sreg_next;

  assign sreg_next = sreg_merge(sreg_reg, wr_mask, wr_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_reg <= SREG_RESET;
    end else begin
      sreg_reg <= sreg_next;
    end
  end

  assign sreg = sreg_reg;

endmodule

// File: rtl/avr_cpu_regfile.sv
// AVR general register file r0..r31 plus SREG. Reads are combinational with no
// write bypass; byte and aligned pair writes land on the rising edge.
module avr_cpu_regfile
  import avr_cpu_pkg::*;
#(
  parameter logic [7:0] REG_RESET  = 8'h00,
  parameter logic [7:0] SREG_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  r_addr,
  input  logic [4:0]  d_addr,
  output logic [7:0]  r_out,
  output logic [7:0]  d_out,
  output logic [15:0] d_word_out,
  input  logic        wr_en,
  input  logic        wr_word,
  input  logic [4:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [7:0]  wr_data_hi,
  output logic [7:0]  status_out,
  input  logic [7:0]  sreg_wr_mask,
  input  logic [7:0]  sreg_wr_data,
  output logic [15:0] x_ptr,
  output logic [15:0] y_ptr,
  output logic [15:0] z_ptr
);

  logic [7:0] regs_reg  [REG_COUNT];
  logic [7:0] regs_next [REG_COUNT];

  logic       word_ok;
  logic       byte_ok;
  logic [4:0] wr_hi_addr;
  logic [4:0] d_lo_addr;
  logic [4:0] d_hi_addr;

  // An odd-based pair write is dropped entirely, including its low byte.
  assign word_ok    = wr_en && wr_word && !wr_addr[0];
  assign byte_ok    = wr_en && !wr_word;
  assign wr_hi_addr = {wr_addr[4:1], 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      logic lo_we;
      logic hi_we;
      assign lo_we = (byte_ok || word_ok) && (wr_addr == 5'(gi));
      assign hi_we = word_ok && (wr_hi_addr == 5'(gi));
      assign regs_next[gi] = lo_we ? wr_data :
                             hi_we ? wr_data_hi : regs_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_reg[i] <= REG_RESET;
      end
    end else begin
      regs_reg <= regs_next;
    end
  end

  assign d_lo_addr = {d_addr[4:1], 1'b0};
  assign d_hi_addr = {d_addr[4:1], 1'b1};

  assign r_out      = regs_reg[r_addr];
  assign d_out      = regs_reg[d_addr];
  assign d_word_out = {regs_reg[d_hi_addr], regs_reg[d_lo_addr]};

  assign x_ptr = {regs_reg[X_BASE + 5'd1], regs_reg[X_BASE]};
  assign y_ptr = {regs_reg[Y_BASE + 5'd1], regs_reg[Y_BASE]};
  assign z_ptr = {regs_reg[Z_BASE + 5'd1], regs_reg[Z_BASE]};

  avr_cpu_sreg #(
    .SREG_RESET (SREG_RESET)
  ) u_sreg (
    .clk     (clk),
    .rst     (rst),
    .wr_mask (sreg_wr_mask),
    .wr_data (sreg_wr_data),
    .sreg    (status_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      odd_word_write: assert (!(wr_en && wr_word && wr_addr[0]))
        else $warning("odd-base pair write to r%0d ignored", wr_addr);
    end
  end

endmodule

// File: tb/tb_avr_cpu_regfile.sv
// Self-checking bench for avr_cpu_regfile: vector table, hand sequences and a
// random phase against a reference model, all checked through a scoreboard queue.
module tb_avr_cpu_regfile;
  import avr_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  r_addr = '0, d_addr = '0, wr_addr = '0;
  logic [7:0]  r_out, d_out, status_out;
  logic [15:0] d_word_out, x_ptr, y_ptr, z_ptr;
  logic        wr_en = 1'b0, wr_word = 1'b0;
  logic [7:0]  wr_data = '0, wr_data_hi = '0, sreg_wr_mask = '0, sreg_wr_data = '0;

  avr_cpu_regfile #(
    .REG_RESET  (8'h00),
    .SREG_RESET (8'h00)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .r_addr       (r_addr),
    .d_addr       (d_addr),
    .r_out        (r_out),
    .d_out        (d_out),
    .d_word_out   (d_word_out),
    .wr_en        (wr_en),
    .wr_word      (wr_word),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_data_hi   (wr_data_hi),
    .status_out   (status_out),
    .sreg_wr_mask (sreg_wr_mask),
    .sreg_wr_data (sreg_wr_data),
    .x_ptr        (x_ptr),
    .y_ptr        (y_ptr),
    .z_ptr        (z_ptr)
  );

  always #5 clk = ~clk;

  localparam int S_R = 0, S_D = 1, S_DW = 2, S_ST = 3, S_X = 4, S_Y = 5, S_Z = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  typedef struct {
    logic        wen;
    logic        wword;
    logic [4:0]  waddr;
    logic [7:0]  wd;
    logic [7:0]  wdh;
    logic [7:0]  mask;
    logic [7:0]  sdata;
    logic [4:0]  ra;
    logic [4:0]  da;
    logic [7:0]  er;
    logic [7:0]  ed;
    logic [15:0] edw;
    logic [7:0]  es;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[13];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_regs [32];
  logic [7:0] m_sreg;

  function automatic logic [15:0] get_out(input int sel);
    case (sel)
      S_R:     return {8'h00, r_out};
      S_D:     return {8'h00, d_out};
      S_DW:    return d_word_out;
      S_ST:    return {8'h00, status_out};
      S_X:     return x_ptr;
      S_Y:     return y_ptr;
      default: return z_ptr;
    endcase
  endfunction

  task automatic push(input string name, input int sel, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic compare_pending();
    exp_t        e;
    logic [15:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = get_out(e.sel);
      n_cmp++;
      if (got !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h, expected %h", e.name, got, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    compare_pending();
  endtask

  task automatic set_inputs(input logic wen, input logic wword, input logic [4:0] waddr,
                            input logic [7:0] wd, input logic [7:0] wdh,
                            input logic [7:0] mask, input logic [7:0] sdata,
                            input logic [4:0] ra, input logic [4:0] da);
    wr_en = wen; wr_word = wword; wr_addr = waddr;
    wr_data = wd; wr_data_hi = wdh;
    sreg_wr_mask = mask; sreg_wr_data = sdata;
    r_addr = ra; d_addr = da;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
    m_sreg = 8'h00;
  endtask

  // Reference behaviour of one clock edge.
  task automatic model_update();
    if (wr_en && !wr_word) begin
      m_regs[wr_addr] = wr_data;
    end else if (wr_en && wr_word && (wr_addr[0] == 1'b0)) begin
      m_regs[wr_addr]        = wr_data;
      m_regs[wr_addr + 5'd1] = wr_data_hi;
    end
    for (int b = 0; b < 8; b++) begin
      if (sreg_wr_mask[b]) m_sreg[b] = sreg_wr_data[b];
    end
  endtask

  task automatic push_model(input string tag);
    logic [4:0] lo;
    lo = {d_addr[4:1], 1'b0};
    push({tag, ".r_out"},  S_R,  {8'h00, m_regs[r_addr]});
    push({tag, ".d_out"},  S_D,  {8'h00, m_regs[d_addr]});
    push({tag, ".d_word"}, S_DW, {m_regs[lo + 5'd1], m_regs[lo]});
    push({tag, ".sreg"},   S_ST, {8'h00, m_sreg});
  endtask

  task automatic do_reset();
    set_inputs(1'b0, 1'b0, 5'd0, 8'h00, 8'h00, 8'h00, 8'h00, 5'd0, 5'd0);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 5'd16, 8'd40, 8'h00, 8'h00, 8'h00, 5'd16, 5'd16, 8'h28, 8'h28, 16'h0028, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 5'd17, 8'd50, 8'h00, 8'h00, 8'h00, 5'd17, 5'd16, 8'h32, 8'h28, 16'h3228, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 5'd16, 8'd90, 8'h00, 8'h00, 8'h00, 5'd17, 5'd16, 8'h32, 8'h5A, 16'h325A, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 5'd26, 8'h34, 8'h12, 8'h00, 8'h00, 5'd26, 5'd27, 8'h34, 8'h12, 16'h1234, 8'h00};
    vecs[4]  = '{1'b1, 1'b1, 5'd27, 8'hAA, 8'hBB, 8'h00, 8'h00, 5'd27, 5'd28, 8'h12, 8'h00, 16'h0000, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 5'd28, 8'hFF, 8'hFF, 8'h00, 8'h00, 5'd28, 5'd29, 8'h00, 8'h00, 16'h0000, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h00, 8'h3F, 8'hC3, 5'd26, 5'd26, 8'h34, 8'h34, 16'h1234, 8'h03};
    vecs[7]  = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h00, 8'h01 << SREG_I, 8'h80, 5'd16, 5'd17, 8'h5A, 8'h32, 16'h325A, 8'h83};
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h00, 8'h00, 8'hFF, 5'd0,  5'd1,  8'h00, 8'h00, 16'h0000, 8'h83};
    vecs[9]  = '{1'b1, 1'b0, 5'd0,  8'h55, 8'h00, 8'h01 << SREG_C, 8'h00, 5'd0, 5'd0, 8'h55, 8'h55, 16'h0055, 8'h82};
    vecs[10] = '{1'b1, 1'b0, 5'd1,  8'h66, 8'h00, 8'h01 << SREG_C, 8'h01, 5'd1, 5'd0, 8'h66, 8'h55, 16'h6655, 8'h83};
    vecs[11] = '{1'b1, 1'b1, 5'd30, 8'h78, 8'h56, 8'h00, 8'h00, 5'd31, 5'd30, 8'h56, 8'h78, 16'h5678, 8'h83};
    vecs[12] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h00, 8'h80, 8'h00, 5'd30, 5'd31, 8'h78, 8'h56, 16'h5678, 8'h03};

    // Reset state.
    model_reset();
    set_inputs(1'b0, 1'b0, 5'd0, 8'h00, 8'h00, 8'h00, 8'h00, 5'd5, 5'd5);
    repeat (2) @(posedge clk);
    #1;
    push("reset.r_out", S_R, 16'h0000);
    push("reset.d_word", S_DW, 16'h0000);
    push("reset.sreg", S_ST, 16'h0000);
    push("reset.x_ptr", S_X, 16'h0000);
    push("reset.y_ptr", S_Y, 16'h0000);
    push("reset.z_ptr", S_Z, 16'h0000);
    compare_pending();
    rst = 1'b0;

    // Asynchronous reset mid-cycle clears state without an edge.
    set_inputs(1'b1, 1'b0, 5'd5, 8'hAA, 8'h00, 8'hFF, 8'h5A, 5'd5, 5'd5);
    push("pre_async.r5", S_R, 16'h00AA);
    push("pre_async.sreg", S_ST, 16'h005A);
    step();
    set_inputs(1'b0, 1'b0, 5'd0, 8'h00, 8'h00, 8'h00, 8'h00, 5'd5, 5'd5);
    #2;
    rst = 1'b1;
    #1;
    push("async_rst.r5", S_R, 16'h0000);
    push("async_rst.sreg", S_ST, 16'h0000);
    compare_pending();
    model_reset();

    // Writes during reset are discarded.
    set_inputs(1'b1, 1'b0, 5'd5, 8'h77, 8'h00, 8'hFF, 8'hFF, 5'd5, 5'd5);
    @(posedge clk);
    #1;
    push("wr_in_rst.r5", S_R, 16'h0000);
    push("wr_in_rst.sreg", S_ST, 16'h0000);
    compare_pending();
    set_inputs(1'b0, 1'b0, 5'd0, 8'h00, 8'h00, 8'h00, 8'h00, 5'd5, 5'd5);
    rst = 1'b0;
    push("post_rst.r5", S_R, 16'h0000);
    push("post_rst.sreg", S_ST, 16'h0000);
    step();

    // Vector table: each row applies one edge and checks the state after it.
    for (int v = 0; v < 13; v++) begin
      set_inputs(vecs[v].wen, vecs[v].wword, vecs[v].waddr, vecs[v].wd, vecs[v].wdh,
                 vecs[v].mask, vecs[v].sdata, vecs[v].ra, vecs[v].da);
      push($sformatf("vec%0d.r_out", v),  S_R,  {8'h00, vecs[v].er});
      push($sformatf("vec%0d.d_out", v),  S_D,  {8'h00, vecs[v].ed});
      push($sformatf("vec%0d.d_word", v), S_DW, vecs[v].edw);
      push($sformatf("vec%0d.sreg", v),   S_ST, {8'h00, vecs[v].es});
      step();
    end
    set_inputs(1'b0, 1'b0, 5'd0, 8'h00, 8'h00, 8'h00, 8'h00, 5'd0, 5'd0);
    push("ptr.x", S_X, 16'h1234);
    push("ptr.y", S_Y, 16'h0000);
    push("ptr.z", S_Z, 16'h5678);
    step();

    // Same-cycle read of a register being written returns the old value.
    do_reset();
    set_inputs(1'b1, 1'b0, 5'd16, 8'd40, 8'h00, 8'h00, 8'h00, 5'd16, 5'd16);
    model_update();
    push_model("seed16");
    step();
    set_inputs(1'b1, 1'b0, 5'd16, 8'd240, 8'h00, 8'h00, 8'h00, 5'd17, 5'd16);
    #1;
    push("same_cycle.old", S_D, {8'h00, 8'd40});
    compare_pending();
    model_update();
    push("same_cycle.new", S_D, {8'h00, 8'd240});
    step();

    // Random traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      set_inputs(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 31)), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      model_update();
      push_model($sformatf("rand%0d", n));
      step();
    end
    set_inputs(1'b0, 1'b0, 5'd0, 8'h00, 8'h00, 8'h00, 8'h00, 5'd0, 5'd0);
    push("rand_end.x", S_X, {m_regs[27], m_regs[26]});
    push("rand_end.y", S_Y, {m_regs[29], m_regs[28]});
    push("rand_end.z", S_Z, {m_regs[31], m_regs[30]});
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
